bus_master: RTL

- Single-outstanding initiator for the system bus; drives HADDR/HWRITE/HWDATA/HVALID into the address decoder and slaves, and collects HRDATA/HREADY from the slave return path.
- Accepts one command at a time from a local user port and returns exactly one response per command: read data, or an error flag.
- HADDR[14:13] selects the region: 01 = slave 1, 10 = slave 2, 11 = slave 3, 00 = unmapped.

---
 rtl/bus_pkg.sv | 23 ++
 rtl/bus_wait_timer.sv | 28 ++
 rtl/bus_master.sv | 135 +++++++++++++
 3 files changed

// File: rtl/bus_pkg.sv
// Shared bus definitions: FSM states, region codes and default widths.
// Used by bus_master and the address decoder.
package bus_pkg;

  localparam int BUS_AW = 15;
  localparam int BUS_DW = 8;

  typedef enum logic [1:0] {
    IDLE,
    XFER,
    RESP
  } state_t;

  localparam logic [1:0] REG_NONE = 2'b00;
  localparam logic [1:0] REG_S1   = 2'b01;
  localparam logic [1:0] REG_S2   = 2'b10;
  localparam logic [1:0] REG_S3   = 2'b11;

  function automatic logic is_mapped(input logic [1:0] region);
    return region != REG_NONE;
  endfunction

endpackage

// File: rtl/bus_wait_timer.sv
// Clearable wait counter; done flags the edge on which the count
// reaches TIMEOUT. Instantiated under BUS_MASTER_TIMEOUT_EN.
module bus_wait_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic done
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= '0;
    else if (clr)
      cnt <= '0;
    else if (en && cnt != CW'(TIMEOUT))
      cnt <= cnt + 1'b1;
  end

  assign done = en && (cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/bus_master.sv
// Single-outstanding bus initiator with a one-command user port.
// Define BUS_MASTER_TIMEOUT_EN to abort transfers stuck on HREADY.
module bus_master
  import bus_pkg::*;
#(
  parameter int AW      = BUS_AW,
  parameter int DW      = BUS_DW,
  parameter int TIMEOUT = 16
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          CMD_VALID,
  output logic          CMD_READY,
  input  logic          CMD_WRITE,
  input  logic [AW-1:0] CMD_ADDR,
  input  logic [DW-1:0] CMD_WDATA,
  output logic          RSP_VALID,
  output logic [DW-1:0] RSP_RDATA,
  output logic          RSP_ERR,
  output logic [AW-1:0] HADDR,
  output logic          HWRITE,
  output logic [DW-1:0] HWDATA,
  output logic          HVALID,
  input  logic [DW-1:0] HRDATA,
  input  logic          HREADY
);

  state_t        state, state_d;
  logic [AW-1:0] haddr_d;
  logic          hwrite_d, hvalid_d;
  logic [DW-1:0] hwdata_d;
  logic [DW-1:0] rd_q, rd_d;
  logic          err_q, err_d;
  logic          rsp_valid_d, rsp_err_d;
  logic [DW-1:0] rsp_rdata_d;
  logic          mapped;
  logic          to_done;

  assign mapped    = is_mapped(CMD_ADDR[AW-1:AW-2]);
  assign CMD_READY = (state == IDLE);

`ifdef BUS_MASTER_TIMEOUT_EN
  bus_wait_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_timer (
    .clk (CLK),
    .rst (RST),
    .clr (state != XFER),
    .en  (state == XFER && !HREADY),
    .done(to_done)
  );
`else
  assign to_done = 1'b0;
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      HADDR     <= '0;
      HWRITE    <= 1'b0;
      HWDATA    <= '0;
      HVALID    <= 1'b0;
      rd_q      <= '0;
      err_q     <= 1'b0;
      RSP_VALID <= 1'b0;
      RSP_RDATA <= '0;
      RSP_ERR   <= 1'b0;
    end else begin
      state     <= state_d;
      HADDR     <= haddr_d;
      HWRITE    <= hwrite_d;
      HWDATA    <= hwdata_d;
      HVALID    <= hvalid_d;
      rd_q      <= rd_d;
      err_q     <= err_d;
      RSP_VALID <= rsp_valid_d;
      RSP_RDATA <= rsp_rdata_d;
      RSP_ERR   <= rsp_err_d;
    end
  end

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE: if (CMD_VALID) state_d = mapped ? XFER : RESP;
      XFER: if (HREADY || to_done) state_d = RESP;
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    haddr_d     = HADDR;
    hwrite_d    = HWRITE;
    hwdata_d    = HWDATA;
    hvalid_d    = HVALID;
    rd_d        = rd_q;
    err_d       = err_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = '0;
    rsp_err_d   = 1'b0;
    unique case (state)
      IDLE: begin
        if (CMD_VALID) begin
          rd_d  = '0;
          err_d = !mapped;
          if (mapped) begin
            haddr_d  = CMD_ADDR;
            hwrite_d = CMD_WRITE;
            hwdata_d = CMD_WRITE ? CMD_WDATA : '0;
            hvalid_d = 1'b1;
          end
        end
      end
      XFER: begin
        if (HREADY || to_done) begin
          // HREADY beats a coincident timeout
          rd_d     = (HREADY && !HWRITE) ? HRDATA : '0;
          err_d    = !HREADY;
          haddr_d  = '0;
          hwrite_d = 1'b0;
          hwdata_d = '0;
          hvalid_d = 1'b0;
        end
      end
      RESP: begin
        rsp_valid_d = 1'b1;
        rsp_rdata_d = rd_q;
        rsp_err_d   = err_q;
      end
      default: ;
    endcase
  end

endmodule
